id_ex_alu_issue: RTL and testbench

//  Drives the ALU (the initiator end of the ALU interface): decodes RV32I instrs from IF/ID, builds imm,

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/alu_imm_gen.sv | 37 +++
 rtl/id_ex_alu_issue.sv | 260 ++++++++++++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the ID/EX issue stage.
//   alu_ctrl_e  : ALU operation codes driven on alu_control
//   imm_type_e  : immediate format selector for alu_imm_gen
//   OPC_*       : major opcodes (instr[6:0]) recognised by the decoder
//   alu_from_funct3 : maps funct3 plus the alternate bit (instr[30]) to an ALU op
package riscv_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ALU_CTRL_W_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers gate it
    // so that OP-IMM never turns ADDI into a subtract.
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate generator.
//   i_instr_hi [31:7] : instruction bits above the opcode
//   i_imm_type        : immediate format (I/S/B/U/J, NONE gives 0)
//   o_imm     [31:0]  : sign-extended immediate (sign taken from instr[31])
module alu_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] i_instr_hi,
    input  imm_type_e   i_imm_type,
    output logic [31:0] o_imm
);

    // Replicated sign bit; each format takes as many fill bits as it needs.
    logic [19:0] w_sign;

    genvar gi;
    generate
        for (gi = 0; gi < 20; gi++) begin : g_sign
            assign w_sign[gi] = i_instr_hi[31];
        end
    endgenerate

    always_comb begin
        o_imm = '0;
        case (i_imm_type)
            IMM_I: o_imm = {w_sign, i_instr_hi[31:20]};
            IMM_S: o_imm = {w_sign, i_instr_hi[31:25], i_instr_hi[11:7]};
            IMM_B: o_imm = {w_sign[18:0], i_instr_hi[31], i_instr_hi[7],
                            i_instr_hi[30:25], i_instr_hi[11:8], 1'b0};
            IMM_U: o_imm = {i_instr_hi[31:12], 12'b0};
            IMM_J: o_imm = {w_sign[10:0], i_instr_hi[31], i_instr_hi[19:12],
                            i_instr_hi[20], i_instr_hi[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes an RV32I instruction from IF/ID, selects ALU
// operands and op code, and holds them in a single ID/EX register towards EX.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : IF/ID handshake (in_instr, in_pc, rs1/rs2 data)
//   flush                    : redirect from EX, drops the entry and the input
//   out_valid/out_ready      : EX handshake
//   operand_a/b, alu_control : ALU inputs
//   out_imm, out_pc, out_rs2_data, out_rd, out_funct3 : side data for EX/MEM
//   out_reg_write/mem_read/mem_write/branch/jump      : control flags
//   illegal_instr            : one-cycle pulse when an unknown opcode is taken
module id_ex_alu_issue
    import riscv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [4:0]            out_rd,
    output logic [2:0]            out_funct3,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic                  illegal_instr
);

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd_field;
    logic [4:0] w_rs1_field;
    logic [4:0] w_rs2_field;
    logic [2:0] w_funct3_field;

    assign w_opcode       = in_instr[6:0];
    assign w_rd_field     = in_instr[11:7];
    assign w_funct3_field = in_instr[14:12];
    assign w_rs1_field    = in_instr[19:15];
    assign w_rs2_field    = in_instr[24:20];

    // Decode results
    imm_type_e       w_imm_type;
    logic [31:0]     w_imm;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    alu_ctrl_e       w_ctrl;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_reg_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_branch;
    logic            w_jump;
    logic            w_illegal;
    logic            w_uses_rs2;
    logic            w_is_shift_imm;

    // ID/EX register
    logic            r_valid;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    alu_ctrl_e       r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs2_data;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_branch;
    logic            r_jump;
    logic            r_illegal;

    logic w_load_use;
    logic w_capture;

    alu_imm_gen u_imm_gen (
        .i_instr_hi (in_instr[31:7]),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    assign w_is_shift_imm = (w_funct3_field == 3'b001) || (w_funct3_field == 3'b101);

    always_comb begin
        w_imm_type  = IMM_NONE;
        w_op_a      = '0;
        w_op_b      = '0;
        w_ctrl      = ALU_ADD;
        w_rd        = w_rd_field;
        w_funct3    = w_funct3_field;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        w_uses_rs2  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_op_a      = rs1_data;
                w_op_b      = rs2_data;
                w_ctrl      = alu_from_funct3(w_funct3_field, in_instr[30]);
                w_reg_write = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm_type  = IMM_I;
                w_op_a      = rs1_data;
                // Shift immediates carry only the shamt; instr[30] is the
                // SRAI selector, not part of the shift amount.
                w_op_b      = w_is_shift_imm ? {27'b0, in_instr[24:20]} : w_imm;
                w_ctrl      = alu_from_funct3(w_funct3_field,
                                              (w_funct3_field == 3'b101) && in_instr[30]);
                w_reg_write = 1'b1;
            end
            OPC_LOAD: begin
                w_imm_type  = IMM_I;
                w_op_a      = rs1_data;
                w_op_b      = w_imm;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            OPC_STORE: begin
                w_imm_type  = IMM_S;
                w_op_a      = rs1_data;
                w_op_b      = w_imm;
                w_rd        = 5'd0;
                w_mem_write = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm_type = IMM_B;
                w_op_a     = rs1_data;
                w_op_b     = rs2_data;
                w_rd       = 5'd0;
                w_branch   = 1'b1;
                w_uses_rs2 = 1'b1;
                case (w_funct3_field[2:1])
                    2'b10:   w_ctrl = ALU_SLT;   // BLT/BGE
                    2'b11:   w_ctrl = ALU_SLTU;  // BLTU/BGEU
                    default: w_ctrl = ALU_SUB;   // BEQ/BNE
                endcase
            end
            OPC_LUI: begin
                w_imm_type  = IMM_U;
                w_op_b      = w_imm;
                w_ctrl      = ALU_PASS_B;
                w_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm_type  = IMM_U;
                w_op_a      = in_pc;
                w_op_b      = w_imm;
                w_reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU computes the link address; the target uses out_imm.
                w_imm_type  = (w_opcode == OPC_JAL) ? IMM_J : IMM_I;
                w_op_a      = in_pc;
                w_op_b      = 32'd4;
                w_reg_write = 1'b1;
                w_jump      = 1'b1;
            end
            default: begin
                w_rd      = 5'd0;
                w_funct3  = 3'd0;
                w_illegal = 1'b1;
            end
        endcase
        if (w_rd == 5'd0) begin
            w_reg_write = 1'b0;
        end
    end

    // rs1 is compared for every format: a false hazard costs one bubble,
    // whereas decoding rs1 usage would lengthen the in_ready path.
    assign w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) &&
                        ((r_rd == w_rs1_field) || (w_uses_rs2 && (r_rd == w_rs2_field)));

    assign in_ready  = !rst && (!r_valid || out_ready) && !flush && !w_load_use;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_ctrl      <= ALU_ADD;
            r_imm       <= '0;
            r_pc        <= '0;
            r_rs2_data  <= '0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid     <= 1'b1;
                r_op_a      <= w_op_a;
                r_op_b      <= w_op_b;
                r_ctrl      <= w_ctrl;
                r_imm       <= w_illegal ? '0 : w_imm;
                r_pc        <= in_pc;
                r_rs2_data  <= rs2_data;
                r_rd        <= w_rd;
                r_funct3    <= w_funct3;
                r_reg_write <= w_reg_write;
                r_mem_read  <= w_mem_read;
                r_mem_write <= w_mem_write;
                r_branch    <= w_branch;
                r_jump      <= w_jump;
                r_illegal   <= w_illegal;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = r_valid;
    assign operand_a     = r_op_a;
    assign operand_b     = r_op_b;
    assign alu_control   = r_ctrl;
    assign out_imm       = r_imm;
    assign out_pc        = r_pc;
    assign out_rs2_data  = r_rs2_data;
    assign out_rd        = r_rd;
    assign out_funct3    = r_funct3;
    assign out_reg_write = r_reg_write;
    assign out_mem_read  = r_mem_read;
    assign out_mem_write = r_mem_write;
    assign out_branch    = r_branch;
    assign out_jump      = r_jump;
    assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed-vector bench for id_ex_alu_issue with hand-computed expectations.
module tb_id_ex_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_jump;
    logic        illegal_instr;

    int n_checks;
    int n_errors;

    id_ex_alu_issue dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .alu_control   (alu_control),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_rs2_data  (out_rs2_data),
        .out_rd        (out_rd),
        .out_funct3    (out_funct3),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_jump      (out_jump),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = a;
        rs2_data = b;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_alu_ctrl", 32'(alu_control), 32'd0);
        rst = 1'b0;

        // add x3,x1,x2
        drive(32'h002081B3, 32'h100, 32'd2, 32'd2);
        #1;
        check("add_in_ready", 32'(in_ready), 32'd1);
        step();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a", operand_a, 32'd2);
        check("add_b", operand_b, 32'd2);
        check("add_ctrl", 32'(alu_control), 32'b0000);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_regw", 32'(out_reg_write), 32'd1);

        // sub x2,x1,x2
        drive(32'h40208133, 32'h104, 32'd9, 32'd8);
        step();
        check("sub_a", operand_a, 32'd9);
        check("sub_b", operand_b, 32'd8);
        check("sub_ctrl", 32'(alu_control), 32'b0001);

        // srai x5,x6,4
        drive(32'h40435293, 32'h108, 32'hF0000200, 32'h0);
        step();
        check("srai_a", operand_a, 32'hF0000200);
        check("srai_b", operand_b, 32'd4);
        check("srai_ctrl", 32'(alu_control), 32'b0111);

        // lw x5,0(x6) followed by dependent add x7,x5,x1
        drive(32'h00032283, 32'h10C, 32'h00000100, 32'h0);
        step();
        check("lw_mem_read", 32'(out_mem_read), 32'd1);
        check("lw_a", operand_a, 32'h100);
        check("lw_rd", 32'(out_rd), 32'd5);
        drive(32'h001283B3, 32'h110, 32'd11, 32'd1);
        #1;
        check("lu_in_ready_stall", 32'(in_ready), 32'd0);
        step();
        check("lu_bubble_valid", 32'(out_valid), 32'd0);
        check("lu_in_ready_after", 32'(in_ready), 32'd1);
        step();
        check("lu_add_valid", 32'(out_valid), 32'd1);
        check("lu_add_rd", 32'(out_rd), 32'd7);
        check("lu_add_a", operand_a, 32'd11);

        // Back-pressure: or x8,x1,x2 waits while EX stalls
        out_ready = 1'b0;
        drive(32'h0020E433, 32'h114, 32'h000000F0, 32'h0000000F);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_rd_hold", 32'(out_rd), 32'd7);
            check("bp_a_hold", operand_a, 32'd11);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("or_rd", 32'(out_rd), 32'd8);
        check("or_ctrl", 32'(alu_control), 32'b1000);
        check("or_a", operand_a, 32'h000000F0);
        check("or_b", operand_b, 32'h0000000F);

        // Flush discards both the held entry and the current input
        flush = 1'b1;
        drive(32'h002081B3, 32'h118, 32'd2, 32'd2);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // lui x10,0x12345
        drive(32'h12345537, 32'h11C, 32'hDEADBEEF, 32'h0);
        step();
        check("lui_a", operand_a, 32'd0);
        check("lui_b", operand_b, 32'h12345000);
        check("lui_ctrl", 32'(alu_control), 32'b1010);
        check("lui_rd", 32'(out_rd), 32'd10);

        // Unknown opcode
        drive(32'h0000007F, 32'h120, 32'd5, 32'd6);
        step();
        check("ill_pulse", 32'(illegal_instr), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_regw", 32'(out_reg_write), 32'd0);
        check("ill_a", operand_a, 32'd0);
        in_valid = 1'b0;
        step();
        check("ill_pulse_end", 32'(illegal_instr), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);

        // jal x1,8
        drive(32'h008000EF, 32'h00001000, 32'd0, 32'd0);
        step();
        check("jal_a", operand_a, 32'h00001000);
        check("jal_b", operand_b, 32'd4);
        check("jal_jump", 32'(out_jump), 32'd1);
        check("jal_imm", out_imm, 32'd8);

        // beq x1,x2,8
        drive(32'h00208463, 32'h00002000, 32'd5, 32'd7);
        step();
        check("beq_ctrl", 32'(alu_control), 32'b0001);
        check("beq_b", operand_b, 32'd7);
        check("beq_imm", out_imm, 32'd8);
        check("beq_branch", 32'(out_branch), 32'd1);

        // addi x1,x0,-1 : sign extension
        drive(32'hFFF00093, 32'h2004, 32'd0, 32'd0);
        step();
        check("addi_b", operand_b, 32'hFFFFFFFF);
        check("addi_ctrl", 32'(alu_control), 32'b0000);

        // add x0,x1,x2 : write to x0 suppressed
        drive(32'h00208033, 32'h2008, 32'd1, 32'd1);
        step();
        check("x0_regw", 32'(out_reg_write), 32'd0);
        check("x0_valid", 32'(out_valid), 32'd1);

        // Reset mid-stream
        drive(32'h002081B3, 32'h200C, 32'd3, 32'd4);
        step();
        check("pre_rst_a", operand_a, 32'd3);
        rst = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_a", operand_a, 32'd0);
        check("midrst_rd", 32'(out_rd), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
